// File: rtl/dff_share_pkg.sv
// Shared types, default sizes and the round-robin pick function for dff_share_arb.
package dff_share_pkg;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;
  localparam int MAX_N        = 16;

  // Rotate req so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                               input logic [3:0]       ptr,
                                               input int               n);
    logic [MAX_N-1:0] rot;
    logic [MAX_N-1:0] first;
    logic [MAX_N-1:0] pick;
    rot  = '0;
    pick = '0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) rot[k] = req[(int'(ptr) + k) % n];
    end
    first = rot & (-rot);
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) pick[(int'(ptr) + k) % n] = first[k];
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_share_arb_rr_picker.sv
// Combinational round-robin picker: one-hot grant plus its binary index.
module rr_picker
  import dff_share_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [MAX_N-1:0] req_ext;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    gnt              = N'(rr_pick(req_ext, 4'(ptr), N));
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = idx | PW'(i);
    end
  end

endmodule

// File: rtl/dff_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit register among N writers.
// Define DFF_SHARE_ARB_LOCK_EN to let a writer hold the grant for up to MAX_HOLD transfers.
module dff_share_arb
  import dff_share_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int PW       = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
  input  logic [N-1:0]       lock,
  output logic [N-1:0]       gnt,
  output logic [WIDTH-1:0]   q,
  output logic               q_valid,
  output logic [PW-1:0]      q_src
);

  logic [PW-1:0]    ptr_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_valid_reg;
  logic [PW-1:0]    q_src_reg;
  logic [N-1:0]     pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic [N-1:0]     gnt_raw;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] wd [N];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
    return (i == PW'(N - 1)) ? '0 : i + PW'(1);
  endfunction

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign wd[gi] = wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_picker #(.N(N)) u_picker (
    .req (req),
    .ptr (ptr_reg),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

`ifdef DFF_SHARE_ARB_LOCK_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t        state_reg;
  logic [PW-1:0] owner_reg;
  logic [HW-1:0] hold_reg;

  always_comb begin
    gnt_raw = pick_gnt;
    gnt_idx = pick_idx;
    if (state_reg == ST_LOCKED) begin
      gnt_raw            = '0;
      gnt_raw[owner_reg] = req[owner_reg];
      gnt_idx            = owner_reg;
    end
  end
`else
  localparam int HOLD_UNUSED = MAX_HOLD;
  logic lock_unused;
  assign lock_unused = ^lock;
  assign gnt_raw     = pick_gnt;
  assign gnt_idx     = pick_idx;
`endif

  assign gnt_any = |gnt_raw;
  assign gnt     = rst ? '0 : gnt_raw;
  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign q_src   = q_src_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
      q_src_reg   <= '0;
      ptr_reg     <= '0;
`ifdef DFF_SHARE_ARB_LOCK_EN
      state_reg   <= ST_IDLE;
      owner_reg   <= '0;
      hold_reg    <= '0;
`endif
    end else begin
      q_valid_reg <= gnt_any;
      if (gnt_any) begin
        q_reg     <= wd[gnt_idx];
        q_src_reg <= gnt_idx;
      end
`ifdef DFF_SHARE_ARB_LOCK_EN
      case (state_reg)
        ST_IDLE: begin
          if (gnt_any) begin
            // A hold limit of one means the lock can never extend past this transfer.
            if (lock[pick_idx] && MAX_HOLD > 1) begin
              state_reg <= ST_LOCKED;
              owner_reg <= pick_idx;
              hold_reg  <= HW'(1);
            end else begin
              ptr_reg <= ptr_inc(pick_idx);
            end
          end
        end
        ST_LOCKED: begin
          if (!gnt_any || !lock[owner_reg] || (int'(hold_reg) + 1 >= MAX_HOLD)) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= ptr_inc(owner_reg);
            hold_reg  <= '0;
          end else begin
            hold_reg  <= hold_reg + HW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
`else
      if (gnt_any) ptr_reg <= ptr_inc(gnt_idx);
`endif
    end
  end

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed table-driven bench for dff_share_arb with N=4, WIDTH=8.
module tb_dff_share_arb;

  localparam logic [31:0] W1  = 32'h13121110;
  localparam logic [31:0] WA5 = 32'h13A51110;
  localparam logic [31:0] WB  = 32'h3C2C1C0C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  q_src;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dff_share_arb #(.N(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .lock    (lock),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_src   (q_src)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [31:0] w,
                     input logic [3:0] g, input logic [7:0] eq, input logic ev, input logic [1:0] es);
    vec_t v;
    v.req = r; v.lock = l; v.wdata = w; v.gnt = g; v.q = eq; v.qv = ev; v.src = es;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  initial begin
    // Registered outputs in each row reflect the edge that closed the previous row.
    add(4'b1111, 4'b0000, W1,  4'b0001, 8'h00, 1'b0, 2'd0);
    add(4'b1111, 4'b0000, W1,  4'b0010, 8'h10, 1'b1, 2'd0);
    add(4'b1111, 4'b0000, W1,  4'b0100, 8'h11, 1'b1, 2'd1);
    add(4'b1111, 4'b0000, W1,  4'b1000, 8'h12, 1'b1, 2'd2);
    add(4'b1111, 4'b0000, W1,  4'b0001, 8'h13, 1'b1, 2'd3);
    add(4'b1111, 4'b0000, W1,  4'b0010, 8'h10, 1'b1, 2'd0);
    add(4'b1111, 4'b0000, W1,  4'b0100, 8'h11, 1'b1, 2'd1);
    add(4'b1111, 4'b0000, W1,  4'b1000, 8'h12, 1'b1, 2'd2);
    add(4'b0000, 4'b0000, W1,  4'b0000, 8'h13, 1'b1, 2'd3);
    add(4'b0000, 4'b0000, W1,  4'b0000, 8'h13, 1'b0, 2'd3);
    add(4'b0100, 4'b0000, WA5, 4'b0100, 8'h13, 1'b0, 2'd3);
    add(4'b0000, 4'b0000, WA5, 4'b0000, 8'hA5, 1'b1, 2'd2);
    add(4'b0000, 4'b0000, WA5, 4'b0000, 8'hA5, 1'b0, 2'd2);
    add(4'b1000, 4'b0000, WB,  4'b1000, 8'hA5, 1'b0, 2'd2);
    add(4'b1001, 4'b0000, WB,  4'b0001, 8'h3C, 1'b1, 2'd3);
    add(4'b1001, 4'b0000, WB,  4'b1000, 8'h0C, 1'b1, 2'd0);
    add(4'b0000, 4'b0000, WB,  4'b0000, 8'h3C, 1'b1, 2'd3);
    add(4'b0000, 4'b0000, WB,  4'b0000, 8'h3C, 1'b0, 2'd3);
    add(4'b0001, 4'b0000, W1,  4'b0001, 8'h3C, 1'b0, 2'd3);
    add(4'b1111, 4'b0010, W1,  4'b0010, 8'h10, 1'b1, 2'd0);
`ifdef DFF_SHARE_ARB_LOCK_EN
    add(4'b1111, 4'b0010, W1,  4'b0010, 8'h11, 1'b1, 2'd1);
    add(4'b1111, 4'b0010, W1,  4'b0010, 8'h11, 1'b1, 2'd1);
    add(4'b1111, 4'b0010, W1,  4'b0010, 8'h11, 1'b1, 2'd1);
    add(4'b1111, 4'b0010, W1,  4'b0100, 8'h11, 1'b1, 2'd1);
    add(4'b0000, 4'b0000, W1,  4'b0000, 8'h12, 1'b1, 2'd2);
`else
    add(4'b1111, 4'b0010, W1,  4'b0100, 8'h11, 1'b1, 2'd1);
    add(4'b1111, 4'b0010, W1,  4'b1000, 8'h12, 1'b1, 2'd2);
    add(4'b1111, 4'b0010, W1,  4'b0001, 8'h13, 1'b1, 2'd3);
    add(4'b1111, 4'b0010, W1,  4'b0010, 8'h10, 1'b1, 2'd0);
    add(4'b0000, 4'b0000, W1,  4'b0000, 8'h11, 1'b1, 2'd1);
`endif

    // Reset held with every requester asking.
    rst = 1'b1; req = 4'b1111; wdata = W1;
    @(posedge clk); @(negedge clk);
    cmp("reset_gnt", 32'(gnt), 32'h0);
    cmp("reset_q", 32'(q), 32'h0);
    cmp("reset_qv", 32'(q_valid), 32'h0);
    cmp("reset_src", 32'(q_src), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      req = vecs[i].req; lock = vecs[i].lock; wdata = vecs[i].wdata;
      #1;
      cmp($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      cmp($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
      cmp($sformatf("v%0d_qv", i), 32'(q_valid), 32'(vecs[i].qv));
      cmp($sformatf("v%0d_src", i), 32'(q_src), 32'(vecs[i].src));
      @(posedge clk); #1;
    end

    // Asynchronous reset between edges while a transfer is pending.
    req = 4'b0100; lock = 4'b0000; wdata = WA5;
    #1;
    cmp("mid_gnt_pre", 32'(gnt), 32'h4);
    @(posedge clk); #1;
    cmp("mid_q_pre", 32'(q), 32'hA5);
    cmp("mid_qv_pre", 32'(q_valid), 32'h1);
    cmp("mid_src_pre", 32'(q_src), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    cmp("mid_q_rst", 32'(q), 32'h0);
    cmp("mid_qv_rst", 32'(q_valid), 32'h0);
    cmp("mid_src_rst", 32'(q_src), 32'h0);
    cmp("mid_gnt_rst", 32'(gnt), 32'h0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cmp("post_rst_qv", 32'(q_valid), 32'h0);
    cmp("post_rst_q", 32'(q), 32'h0);
    req = 4'b1111; wdata = W1;
    #1;
    cmp("post_rst_ptr", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    cmp("post_rst_first_q", 32'(q), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dff_share_arb.md
Name: dff_share_arb

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register among N requesters.
- Each cycle, at most one requester writes its data into the shared register.
- The register output and the identity of the last writer go to downstream logic.
- Sits between multiple producer blocks and a single shared state register in the design.

Parameters:
- N, 4, number of requesters (2..16)
- WIDTH, 8, data width of the shared register
- MAX_HOLD, 4, maximum consecutive cycles one requester may keep the grant while locked (LOCK_EN only)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester write request (level)
- wdata  input  N*WIDTH  flattened write data; requester i drives bits [i*WIDTH +: WIDTH]
- lock  input  N  per-requester lock hint; used only with LOCK_EN
- gnt  output  N  one-hot grant, combinational from req and the registered pointer/state
- q  output  WIDTH  shared register contents
- q_valid  output  1  high for one cycle after each write edge
- q_src  output  $clog2(N)  index of the requester that performed the last write

Behaviour:
- Reset (asynchronous, active-high), all registered outputs and state cleared:
  - q=0, q_valid=0, q_src=0
  - round-robin pointer ptr=0; state IDLE; hold counter 0
  - gnt=0 while rst is high, regardless of req
- Arbitration (combinational):
  - Search starts at index ptr and wraps modulo N.
  - gnt = one-hot of the first i with req[i]=1; gnt=0 if req=0.
  - At most one gnt bit is high; gnt[i] is never high unless req[i] is high.
- Transfer: on a rising edge with gnt[i]=1:
  - q <= wdata[i], q_src <= i, q_valid <= 1
  - ptr <= (i+1) mod N; wrap from N-1 to 0
- On an edge with no grant: q and q_src hold; q_valid <= 0.
- Latency: data presented with gnt in cycle t appears on q in cycle t+1.
- Requester contract:
  - Hold req and wdata stable until the cycle gnt[i] is seen.
  - req high in a cycle with gnt[i] counts as one transfer; back-to-back cycles are allowed but rotate fairly.
- Fairness: with all N requesting continuously, grants cycle 0,1,...,N-1,0,...; any requester waits at most N-1 cycles.
- Simultaneous requests: resolved by ptr only; no fixed priority.
- req dropped before the edge: no transfer and no state change for that requester.
- rst asserted mid-operation: an in-flight transfer is discarded; q returns to 0 immediately.

Optional Feature:
- Macro: DFF_SHARE_ARB_LOCK_EN.
- Defined: a two-state FSM is added.
  - IDLE → LOCKED when a transfer occurs with lock[i]=1; record owner=i and set hold count to 1.
  - In LOCKED, gnt = one-hot(owner) if req[owner]=1, else 0. Other requesters are blocked; ptr is frozen.
  - Each owner transfer increments the hold count.
  - LOCKED → IDLE, with ptr <= owner+1, when any of the following occurs:
    - lock[owner]=0 at a transfer edge
    - req[owner]=0 for one cycle
    - hold count reaches MAX_HOLD
- Not defined: the lock input is ignored, there is no FSM, and pure round-robin applies.

Decomposition:
- Shared package dff_share_pkg:
  - state enum (ST_IDLE, ST_LOCKED)
  - function rr_pick(req, ptr) returning a one-hot vector
  - default-width constants
- One natural sub-module, rr_picker: a combinational rotate/priority-encode/rotate-back producing gnt and a binary index.
- Storage, pointer and FSM live in the top module.

Test Plan:
- Reset: rst=1 while req=4'b1111 → gnt=0, q=0, q_valid=0; after rst deasserts, first grant goes to requester 0.
- Single requester: req=4'b0100, wdata[2]=8'hA5 → gnt=4'b0100 the same cycle; next cycle q=8'hA5, q_src=2, q_valid=1; q_valid=0 after req drops.
- Full contention, 8 cycles with req=4'b1111 and wdata[i]=8'h10+i → q sequence 10,11,12,13,10,11,12,13; no requester is skipped.
- Wrap-around/pointer: grant requester 3, then req=4'b1001 → next grant to 0 (wrap), then to 3.
- Mid-operation reset: assert rst asynchronously between edges during a transfer → q=0 immediately; ptr=0; no q_valid pulse afterwards.
- LOCK_EN:
  - MAX_HOLD=4, requester 1 with lock=1 and req=4'b1111 → exactly 4 consecutive grants to 1, then grant to 2.
  - Without the macro, same stimulus → grants 1,2,3,0.
